chan_arb_mux: RTL and testbench

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every input and on the output. It generalises the 8:1 gate-level select mux to arbitrary channel count and data width. It adds round-robin, fixed-priority and forced-select modes, and backpressure handling. It sits between multiple producer channels and a single downstream consumer.

---
 rtl/chan_arb_pkg.sv | 13 +
 rtl/chan_arb_mux_rr_arbiter.sv | 35 +++
 rtl/chan_arb_mux.sv | 70 +++++++
 tb/tb_chan_arb_mux.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/chan_arb_pkg.sv
// rtl/chan_arb_pkg.sv - shared mode constants and round-robin wrap helper
package chan_arb_pkg;

  localparam logic [1:0] MODE_RR     = 2'b00;
  localparam logic [1:0] MODE_FIXED  = 2'b01;
  localparam logic [1:0] MODE_FORCED = 2'b10;

  // Operands are always below 2*n, so a single conditional subtract is a full mod n.
  function automatic int rr_wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/chan_arb_mux_rr_arbiter.sv
// rtl/chan_arb_mux_rr_arbiter.sv - combinational round-robin / fixed-priority grant picker
module rr_arbiter
  import chan_arb_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 fixed,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int SW = $clog2(N);

  int   idx;
  logic found;

  // Fixed priority is the same upward scan with the starting point pinned at 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = fixed ? k : rr_wrap(int'(ptr) + k, N);
      if (!found && elig[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_arb_mux.sv
// rtl/chan_arb_mux.sv - N-channel arbitrating mux with registered output slot
module chan_arb_mux
  import chan_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  input  logic [1:0]     mode,
  input  logic [SW-1:0]  sel,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic [N-1:0]  elig;
  logic [N-1:0]  grant;
  logic [SW-1:0] grant_idx;
  logic          sel_ok;
  logic          slot_open;
  logic          xfer;

  assign sel_ok = int'(sel) < N;

  always_comb begin
    elig = '0;
    if (mode == MODE_FORCED) begin
      if (sel_ok) elig[sel] = in_valid[sel];
    end else begin
      elig = in_valid;
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .elig      (elig),
    .ptr       (ptr),
    .fixed     (mode == MODE_FIXED),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign slot_open = !out_valid || out_ready;
  // rst gates in_ready so nothing is offered while the output slot is being cleared.
  assign in_ready  = (slot_open && !rst) ? grant : '0;
  assign xfer      = |(in_valid & in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(grant_idx)*W +: W];
      out_ch    <= grant_idx;
      ptr       <= SW'(rr_wrap(int'(grant_idx) + 1, N));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_arb_mux.sv
// tb/tb_chan_arb_mux.sv - self-checking bench for chan_arb_mux (N=8 and N=5 instances)
module tb_chan_arb_mux;
  import chan_arb_pkg::*;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;
  localparam int N5 = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic [1:0]     mode;
  logic [SW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_ready;

  logic [N5-1:0]   in_valid5;
  logic [N5*W-1:0] in_data5;
  logic [N5-1:0]   in_ready5;
  logic [1:0]      mode5;
  logic [2:0]      sel5;
  logic            out_valid5;
  logic [W-1:0]    out_data5;
  logic [2:0]      out_ch5;
  logic            out_ready5;

  always #5 clk = ~clk;

  chan_arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  chan_arb_mux #(.N(N5), .W(W)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5), .out_valid(out_valid5), .out_data(out_data5), .out_ch(out_ch5),
    .out_ready(out_ready5)
  );

  typedef struct { int ch; int data; } beat_t;
  typedef struct {
    logic [1:0] mode;
    int         sel;
    logic [7:0] valid;
    bit         ordy;
    int         cycles;
    int         exp_xfers;
  } vec_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;
  int    m_ptr;
  bit    m_valid;
  int    xfers;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [1:0] md, input int s, input logic [N-1:0] v, input int p);
    if (md == MODE_FORCED) return (s < N && v[s]) ? s : -1;
    if (md == MODE_FIXED) begin
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
    end
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // One clock: check against the model just after the negedge, then advance to the next negedge.
  task automatic step();
    int         g;
    logic [N-1:0] exp_rdy;
    beat_t      b;
    #1;
    g       = model_grant(mode, int'(sel), in_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0 && (!m_valid || out_ready)) exp_rdy[g] = 1'b1;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'(0), 64'(1));
      end else begin
        b = sb.pop_front();
        check("out_ch", 64'(out_ch), 64'(b.ch));
        check("out_data", 64'(out_data), 64'(b.data));
      end
    end
    if (exp_rdy != 0) begin
      sb.push_back('{ch: g, data: 8'hA0 + g});
      m_ptr   = (g + 1) % N;
      m_valid = 1'b1;
      xfers++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  vec_t vecs[8];
  int   exp5_ch[4];
  int   exp5_ptr[4];
  int   p_hold;

  initial begin
    vecs[0] = '{MODE_FIXED,  0, 8'h24, 1'b1, 4, 4};
    vecs[1] = '{MODE_FORCED, 5, 8'hFF, 1'b1, 3, 3};
    vecs[2] = '{MODE_FORCED, 5, 8'hDF, 1'b1, 2, 0};
    vecs[3] = '{2'b11,       0, 8'h81, 1'b1, 3, 3};
    vecs[4] = '{MODE_RR,     0, 8'h00, 1'b0, 2, 0};
    vecs[5] = '{MODE_RR,     0, 8'h0F, 1'b0, 2, 0};
    vecs[6] = '{MODE_RR,     0, 8'h0F, 1'b1, 4, 4};
    vecs[7] = '{MODE_FIXED,  0, 8'h00, 1'b1, 2, 0};
    exp5_ch  = '{3, 4, 3, 4};
    exp5_ptr = '{4, 0, 4, 0};

    rst = 1'b1;
    in_valid = '0; mode = MODE_RR; sel = '0; out_ready = 1'b0;
    in_valid5 = '0; mode5 = MODE_RR; sel5 = '0; out_ready5 = 1'b0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = 8'(8'hA0 + i);
    for (int i = 0; i < N5; i++) in_data5[i*W +: W] = 8'(8'h50 + i);
    m_ptr = 0; m_valid = 1'b0; xfers = 0;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;

    // Round-robin fairness from release.
    in_valid = 8'hFF; out_ready = 1'b1; mode = MODE_RR;
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_ch", 64'(out_ch), 64'(i % N));
      check("rr_data", 64'(out_data), 64'(8'hA0 + (i % N)));
      check("rr_valid", 64'(out_valid), 64'(1));
    end

    for (int r = 0; r < 8; r++) begin
      mode = vecs[r].mode; sel = SW'(vecs[r].sel);
      in_valid = vecs[r].valid; out_ready = vecs[r].ordy;
      xfers = 0;
      for (int c = 0; c < vecs[r].cycles; c++) step();
      check($sformatf("row%0d_xfers", r), 64'(xfers), 64'(vecs[r].exp_xfers));
    end

    // Backpressure: fill the slot, then stall three cycles.
    mode = MODE_RR; in_valid = 8'hFF; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    p_hold = m_ptr;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_ch", 64'(out_ch), 64'(sb[0].ch));
      check("bp_data", 64'(out_data), 64'(sb[0].data));
      check("bp_ptr", 64'(dut.ptr), 64'(p_hold));
    end
    out_ready = 1'b1;
    step();
    check("bp_refill_ch", 64'(out_ch), 64'(p_hold));
    step();

    // Asynchronous reset with a beat in flight.
    check("pre_rst_valid", 64'(out_valid), 64'(1));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_data", 64'(out_data), 64'(0));
    check("mid_rst_out_ch", 64'(out_ch), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    sb.delete(); m_valid = 1'b0; m_ptr = 0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = '0;
    #1 check("post_rst_ptr", 64'(dut.ptr), 64'(0));

    // Non-power-of-two wrap on the N=5 instance.
    @(negedge clk);
    in_valid5 = 5'b11000; out_ready5 = 1'b1; mode5 = MODE_RR;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("n5_valid", 64'(out_valid5), 64'(1));
      check("n5_ch", 64'(out_ch5), 64'(exp5_ch[i]));
      check("n5_data", 64'(out_data5), 64'(8'h50 + exp5_ch[i]));
      check("n5_ptr", 64'(dut5.ptr), 64'(exp5_ptr[i]));
    end
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
